// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, oversampling constants and decode helpers
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [1:0] {
    BITS_5 = 2'b00,
    BITS_6 = 2'b01,
    BITS_7 = 2'b10,
    BITS_8 = 2'b11
  } data_bits_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DELIVER
  } rx_state_t;

  // Code 11 is a second spelling of "no parity".
  function automatic parity_mode_t decode_parity(input logic [1:0] mode);
    case (mode)
      2'b01:   return EVEN;
      2'b10:   return ODD;
      default: return NONE;
    endcase
  endfunction

  function automatic logic [2:0] last_bit_idx(input data_bits_t bits);
    return 3'd4 + {1'b0, bits};
  endfunction
endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage synchroniser for asynchronous idle-high lines
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] r_sync;

  // Resetting to 1 keeps an idle-high line from looking like a start bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x oversampling UART receive engine with valid/ack output
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_MAX    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                ov_baud_rt_i,
  input  logic                rx_i,
  input  logic [1:0]          data_bits_i,
  input  logic [1:0]          parity_mode_i,
  input  logic                stop_bits_i,
  input  logic                rx_ack_i,
  output logic [DATA_MAX-1:0] rx_data_o,
  output logic                rx_valid_o,
  output logic                parity_err_o,
  output logic                frame_err_o,
  output logic                overrun_o,
  output logic                busy_o
);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  logic                w_rx;
  rx_state_t           r_state;
  rx_state_t           w_next_state;
  logic [3:0]          r_tick_cnt;
  logic [2:0]          r_bit_cnt;
  logic [DATA_MAX-1:0] r_shift;
  logic                r_par_acc;
  logic                r_par_err;
  logic                r_frame_err;
  logic                r_stop_cnt;
  data_bits_t          r_data_bits;
  parity_mode_t        r_parity;
  logic                r_stop2;

  logic [DATA_MAX-1:0] r_rx_data;
  logic                r_rx_valid;
  logic                r_parity_err;
  logic                r_frame_err_out;
  logic                r_overrun;

  logic w_mid_tick;
  logic w_bit_tick;
  logic w_busy;
  logic w_enter_start;
  logic w_sample_data;
  logic w_sample_par;
  logic w_sample_stop;
  logic w_deliver;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rx_i),
    .q_o     (w_rx)
  );

  assign w_mid_tick = ov_baud_rt_i && (r_tick_cnt == MID_TICK);
  assign w_bit_tick = ov_baud_rt_i && (r_tick_cnt == LAST_TICK);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_rx) w_next_state = START;
      START:   if (w_mid_tick) w_next_state = w_rx ? IDLE : DATA;
      DATA:    if (w_bit_tick && (r_bit_cnt == last_bit_idx(r_data_bits)))
                 w_next_state = (r_parity != NONE) ? PARITY : STOP;
      PARITY:  if (w_bit_tick) w_next_state = STOP;
      STOP:    if (w_bit_tick && (r_stop_cnt || !r_stop2)) w_next_state = DELIVER;
      DELIVER: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_busy        = (r_state != IDLE);
    w_enter_start = (r_state == IDLE) && !w_rx;
    w_sample_data = (r_state == DATA) && w_bit_tick;
    w_sample_par  = (r_state == PARITY) && w_bit_tick;
    w_sample_stop = (r_state == STOP) && w_bit_tick;
    w_deliver     = (r_state == DELIVER);
  end

  // Frame datapath; configuration is frozen at START so mid-frame changes wait a frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_acc   <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_stop_cnt  <= 1'b0;
      r_data_bits <= BITS_8;
      r_parity    <= NONE;
      r_stop2     <= 1'b0;
    end else begin
      if (w_next_state != r_state) begin
        r_tick_cnt <= '0;
      end else if (ov_baud_rt_i) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
      end
      if (w_enter_start) begin
        r_data_bits <= data_bits_t'(data_bits_i);
        r_parity    <= decode_parity(parity_mode_i);
        r_stop2     <= stop_bits_i;
        r_shift     <= '0;
        r_bit_cnt   <= '0;
        r_par_acc   <= 1'b0;
        r_par_err   <= 1'b0;
        r_frame_err <= 1'b0;
        r_stop_cnt  <= 1'b0;
      end
      if (w_sample_data) begin
        r_shift[r_bit_cnt] <= w_rx;
        r_par_acc          <= r_par_acc ^ w_rx;
        r_bit_cnt          <= r_bit_cnt + 3'd1;
      end
      if (w_sample_par) begin
        r_par_err <= (r_parity == ODD) ? ~(r_par_acc ^ w_rx) : (r_par_acc ^ w_rx);
      end
      if (w_sample_stop) begin
        if (!w_rx) r_frame_err <= 1'b1;
        r_stop_cnt <= 1'b1;
      end
    end
  end

  // A delivery in the same cycle as an ack wins and does not count as an overrun.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_parity_err    <= 1'b0;
      r_frame_err_out <= 1'b0;
      r_overrun       <= 1'b0;
    end else if (w_deliver) begin
      r_rx_data       <= r_shift;
      r_parity_err    <= r_par_err;
      r_frame_err_out <= r_frame_err;
      r_overrun       <= r_rx_valid && !rx_ack_i;
      r_rx_valid      <= 1'b1;
    end else if (rx_ack_i && r_rx_valid) begin
      r_rx_valid      <= 1'b0;
      r_parity_err    <= 1'b0;
      r_frame_err_out <= 1'b0;
      r_overrun       <= 1'b0;
    end
  end

  assign rx_data_o    = r_rx_data;
  assign rx_valid_o   = r_rx_valid;
  assign parity_err_o = r_parity_err;
  assign frame_err_o  = r_frame_err_out;
  assign overrun_o    = r_overrun;
  assign busy_o       = w_busy;
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int BIT_CLKS = 256;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       ov_baud_rt_i = 1'b0;
  logic       rx_i = 1'b1;
  logic [1:0] data_bits_i = 2'b11;
  logic [1:0] parity_mode_i = 2'b00;
  logic       stop_bits_i = 1'b0;
  logic       rx_ack_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int n_cmp = 0;
  int n_err = 0;

  uart_receiver #(.DATA_MAX(8), .SYNC_STAGES(2)) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .ov_baud_rt_i  (ov_baud_rt_i),
    .rx_i          (rx_i),
    .data_bits_i   (data_bits_i),
    .parity_mode_i (parity_mode_i),
    .stop_bits_i   (stop_bits_i),
    .rx_ack_i      (rx_ack_i),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o),
    .overrun_o     (overrun_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    forever begin
      @(negedge clk_i) ov_baud_rt_i = 1'b1;
      @(negedge clk_i) ov_baud_rt_i = 1'b0;
      repeat (14) @(negedge clk_i);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                            input bit par_odd, input bit par_flip, input bit stop_a,
                            input bit stop_b, input bit two_stop);
    logic p;
    p = par_odd;
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      send_bit(data[i]);
      p = p ^ data[i];
    end
    if (par_en) send_bit(p ^ par_flip);
    send_bit(stop_a);
    if (two_stop) send_bit(stop_b);
    rx_i = 1'b1;
  endtask

  task automatic do_ack(input string tag);
    @(negedge clk_i) rx_ack_i = 1'b1;
    @(negedge clk_i) rx_ack_i = 1'b0;
    check(tag, {31'd0, rx_valid_o}, 32'd0);
  endtask

  initial begin
    bit found;
    repeat (5) @(negedge clk_i);
    check("reset_valid", {31'd0, rx_valid_o}, 32'd0);
    check("reset_data", {24'd0, rx_data_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_flags", {29'd0, parity_err_o, frame_err_o, overrun_o}, 32'd0);
    rst_n_i = 1'b1;
    repeat (40) @(negedge clk_i);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 0, 0, 0, 1, 1, 0);
    check("a5_valid", {31'd0, rx_valid_o}, 32'd1);
    check("a5_data", {24'd0, rx_data_o}, 32'hA5);
    check("a5_flags", {29'd0, parity_err_o, frame_err_o, overrun_o}, 32'd0);
    do_ack("a5_ack_clears");

    // 7E1 0x53, correct then flipped parity
    data_bits_i = 2'b10;
    parity_mode_i = 2'b01;
    send_frame(8'h53, 7, 1, 0, 0, 1, 1, 0);
    check("p53_valid", {31'd0, rx_valid_o}, 32'd1);
    check("p53_data", {24'd0, rx_data_o}, 32'h53);
    check("p53_perr", {31'd0, parity_err_o}, 32'd0);
    do_ack("p53_ack");
    send_frame(8'h53, 7, 1, 0, 1, 1, 1, 0);
    check("p53f_data", {24'd0, rx_data_o}, 32'h53);
    check("p53f_perr", {31'd0, parity_err_o}, 32'd1);
    do_ack("p53f_ack");
    check("p53f_perr_cleared", {31'd0, parity_err_o}, 32'd0);

    // 4-tick glitch
    data_bits_i = 2'b11;
    parity_mode_i = 2'b00;
    rx_i = 1'b0;
    repeat (64) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (512) @(negedge clk_i);
    check("glitch_valid", {31'd0, rx_valid_o}, 32'd0);
    check("glitch_busy", {31'd0, busy_o}, 32'd0);

    // 0x3C with a low stop bit
    send_frame(8'h3C, 8, 0, 0, 0, 0, 1, 0);
    check("fe3c_data", {24'd0, rx_data_o}, 32'h3C);
    check("fe3c_ferr", {31'd0, frame_err_o}, 32'd1);
    check("fe3c_perr", {31'd0, parity_err_o}, 32'd0);
    repeat (14 * BIT_CLKS) @(negedge clk_i);
    do_ack("fe3c_ack");

    // 5N2 0x1F with the second stop bit low
    data_bits_i = 2'b00;
    stop_bits_i = 1'b1;
    send_frame(8'h1F, 5, 0, 0, 0, 1, 0, 1);
    check("s2_data", {24'd0, rx_data_o}, 32'h1F);
    check("s2_ferr", {31'd0, frame_err_o}, 32'd1);
    repeat (14 * BIT_CLKS) @(negedge clk_i);
    do_ack("s2_ack");
    data_bits_i = 2'b11;
    stop_bits_i = 1'b0;

    // Overrun: 0x11 then 0x22 with no ack
    send_frame(8'h11, 8, 0, 0, 0, 1, 1, 0);
    check("ov11_data", {24'd0, rx_data_o}, 32'h11);
    check("ov11_over", {31'd0, overrun_o}, 32'd0);
    send_frame(8'h22, 8, 0, 0, 0, 1, 1, 0);
    check("ov22_data", {24'd0, rx_data_o}, 32'h22);
    check("ov22_over", {31'd0, overrun_o}, 32'd1);
    check("ov22_valid", {31'd0, rx_valid_o}, 32'd1);
    do_ack("ov22_ack");
    check("ov22_over_cleared", {31'd0, overrun_o}, 32'd0);

    // Ack coincident with the second DELIVER
    send_frame(8'h55, 8, 0, 0, 0, 1, 1, 0);
    found = 1'b0;
    fork
      send_frame(8'h66, 8, 0, 0, 0, 1, 1, 0);
      begin
        for (int i = 0; i < 12 * BIT_CLKS; i++) begin
          @(negedge clk_i);
          if (dut.r_state == DELIVER) begin
            found = 1'b1;
            rx_ack_i = 1'b1;
            @(negedge clk_i) rx_ack_i = 1'b0;
            break;
          end
        end
      end
    join
    check("co_deliver_seen", {31'd0, found}, 32'd1);
    check("co_data", {24'd0, rx_data_o}, 32'h66);
    check("co_valid", {31'd0, rx_valid_o}, 32'd1);
    check("co_over", {31'd0, overrun_o}, 32'd0);

    // Reset during data bit 3, with 0x66 still pending
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_i = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk_i);
    check("rst_busy_before", {31'd0, busy_o}, 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_busy_async", {31'd0, busy_o}, 32'd0);
    check("rst_valid_async", {31'd0, rx_valid_o}, 32'd0);
    check("rst_data_async", {24'd0, rx_data_o}, 32'd0);
    repeat (4) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk_i);
    check("rst_no_partial", {31'd0, rx_valid_o}, 32'd0);
    send_frame(8'h7E, 8, 0, 0, 0, 1, 1, 0);
    check("post_rst_data", {24'd0, rx_data_o}, 32'h7E);
    check("post_rst_valid", {31'd0, rx_valid_o}, 32'd1);
    check("post_rst_flags", {29'd0, parity_err_o, frame_err_o, overrun_o}, 32'd0);
    do_ack("post_rst_ack");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
16x-oversampling UART receive engine, paired with the baud rate generator.
- Timing input is only the oversampling tick ov_baud_rt_i. The receiver has no baud counter of its own.
- Synchronises the serial input, detects and qualifies the start bit, and samples data, parity and stop bits at mid-bit.
- Presents each received character through a valid/ack handshake, with parity, framing and overrun status, to the UART register/FIFO layer.

Parameters:
DATA_MAX, 8, width of rx_data_o; the maximum data bits per frame.
SYNC_STAGES, 2, number of flip-flops in the rx_i synchroniser (minimum 2).

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  asynchronous active-low reset
ov_baud_rt_i  input  1  one-cycle pulse at 16x the baud rate
rx_i  input  1  asynchronous serial line; idles high
data_bits_i  input  2  data bits per frame: 00=5, 01=6, 10=7, 11=8
parity_mode_i  input  2  00=none, 01=even, 10=odd, 11=none
stop_bits_i  input  1  0=one stop bit, 1=two stop bits
rx_ack_i  input  1  consumer takes the character; clears rx_valid_o
rx_data_o  output  DATA_MAX  received character, right-justified, unused MSBs zero
rx_valid_o  output  1  character available; held until acknowledged
parity_err_o  output  1  parity error on the presented character
frame_err_o  output  1  a stop bit was sampled low
overrun_o  output  1  a new character completed while rx_valid_o was high
busy_o  output  1  high while the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Synchroniser flops reset to 1, so no false start bit at reset release.
  - Assertion mid-frame aborts the frame immediately; no partial character is presented.
- Configuration: data_bits_i, parity_mode_i and stop_bits_i are latched on entry to START. Changes during a frame take effect on the next frame.
- Tick counter: 4-bit tick_cnt, advanced only on cycles where ov_baud_rt_i=1. It is cleared on every state transition.
- IDLE:
  - Synchronised rx = 0 -> START, tick_cnt=0.
- START:
  - On the 8th tick (tick_cnt==7 with tick high), sample rx.
  - rx=0 -> DATA.
  - rx=1 -> glitch: return to IDLE with no error flag.
- DATA:
  - On every 16th tick (tick_cnt==15 with tick high), shift the sampled bit in, LSB first.
  - After N bits (N = 5..8), go to PARITY if parity is enabled, else to STOP.
- PARITY:
  - Sample at tick 16.
  - Error = (XOR of the data bits XOR the parity bit) != 0 for even, == 0 for odd.
- STOP:
  - Sample at tick 16; a sampled 0 sets the frame-error flag for this frame.
  - If stop_bits=1, sample a second stop bit the same way.
  - After the last stop bit -> DELIVER.
  - No wait for the bit end: the mid-stop-bit return allows back-to-back frames.
- DELIVER (one cycle), then IDLE:
  - rx_data_o, parity_err_o and frame_err_o are loaded.
  - If rx_valid_o is already 1 and rx_ack_i=0 in the same cycle, overrun_o is set and the new data overwrites the old.
  - rx_valid_o is set.
- Latency: rx_valid_o rises 2 clk_i cycles after the tick that samples the last stop bit.
- Handshake:
  - rx_ack_i while rx_valid_o=1 clears rx_valid_o, parity_err_o, frame_err_o and overrun_o on the next edge.
  - rx_ack_i while rx_valid_o=0 is ignored.
  - Ack and DELIVER in the same cycle: the new character wins. rx_valid_o stays 1 with the new status; overrun_o is not set.
- Break (all zeros plus a low stop bit): delivered as data 0 with frame_err_o=1. No special state.
- Ticks: ov_baud_rt_i held low stalls the FSM indefinitely; this is legal.

Decomposition:
- Shared package uart_pkg:
  - parity_mode_t enum (NONE, EVEN, ODD).
  - data_bits_t encoding.
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP, DELIVER).
  - Constant OVERSAMPLE=16 and constant MID_SAMPLE=7.
- One sub-module, sync_ff: parameterised SYNC_STAGES synchroniser with reset value 1, reusable by the transmitter CTS path.

Test Plan:
- Basic frame: 8N1, 16-cycle tick period, byte 0xA5 sent LSB first -> rx_data_o=0xA5, rx_valid_o=1, all error flags 0; rx_ack_i pulse -> rx_valid_o=0 on the next edge.
- Data length and parity: 7 data bits, even parity, 0x53 with a correct parity bit (0) -> data 0x53, parity_err_o=0. The same frame with the parity bit flipped -> parity_err_o=1.
- Glitch and framing: a 4-tick low pulse on an idle line -> back to IDLE, no rx_valid_o. A 0x3C frame with the stop bit driven low -> rx_data_o=0x3C, frame_err_o=1.
- Overrun: two back-to-back 8N1 frames, 0x11 then 0x22, no ack -> rx_data_o=0x22, overrun_o=1. An ack coincident with the second DELIVER -> overrun_o=0.
- Two stop bits: stop_bits_i=1, 5-bit 0x1F, second stop bit low -> frame_err_o=1, data 0x1F (upper 3 bits 0).
- Reset mid-frame: rst_n_i asserted during DATA bit 3 -> outputs 0, busy_o=0 immediately (asynchronously). A following clean 0x7E frame is received correctly.
